argmax_stream: RTL

- Parametrised streaming arg-max unit for the NPU output layer. Successor to the two-input auto comparator.
- Takes a frame of N_CLASSES signed scores over LANES lanes per beat, using a valid/ready handshake.
- Tracks the largest and second-largest score and the class index of the largest.
- Reports a confidence margin and a one-cycle DONE pulse per frame.

---
 rtl/argmax_stream.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/argmax_stream.sv
// rtl/argmax_stream.sv - streaming signed arg-max with runner-up score and confidence margin
//
// Consumes one frame of N_CLASSES signed scores, LANES scores per accepted beat,
// and reports the largest score, the runner-up, the class index of the largest
// and their difference.
//
// Ports:
//   CLKEXT        clock, rising edge
//   RST_ARGMAX    asynchronous active-high reset
//   EN            global enable; low freezes all state and drops IN_READY
//   START         one-cycle pulse opening a new frame (aborts a frame in progress)
//   IN_VALID      beat valid
//   IN_READY      beat accepted when IN_VALID & IN_READY
//   IN_DATA       lane k in bits [k*DATA_W +: DATA_W], class = beat*LANES + k
//   LARGEST       max score of the last completed frame
//   SECOND        runner-up score of the last completed frame
//   INDEX         class index of LARGEST
//   MARGIN        LARGEST - SECOND, DATA_W+1 bits, never negative
//   DONE          one-cycle pulse while the new result is first presented
//   RESULT_VALID  high from DONE until the next accepted START
//   BUSY          frame in progress
//   ABORT         one-cycle pulse after a START that discarded a frame
module argmax_stream #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 2,
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = 8
) (
  input  logic                    CLKEXT,
  input  logic                    RST_ARGMAX,
  input  logic                    EN,
  input  logic                    START,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  input  logic [LANES*DATA_W-1:0] IN_DATA,
  output logic [DATA_W-1:0]       LARGEST,
  output logic [DATA_W-1:0]       SECOND,
  output logic [IDX_W-1:0]        INDEX,
  output logic [DATA_W:0]         MARGIN,
  output logic                    DONE,
  output logic                    RESULT_VALID,
  output logic                    BUSY,
  output logic                    ABORT
);

  localparam int BEATS = (N_CLASSES + LANES - 1) / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic signed [DATA_W-1:0] sec_q, sec_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]        largest_q, largest_d;
  logic [DATA_W-1:0]        second_q, second_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [DATA_W:0]          margin_q, margin_d;
  logic                     rvalid_q, rvalid_d;
  logic                     abort_q, abort_d;

  logic signed [DATA_W-1:0] chain_max, chain_sec, lane_v;
  logic [IDX_W-1:0]         chain_idx;
  int                       lane_cls;
  logic                     open_frame, beat_fire;

  // Running state after folding in the current beat, lanes in ascending class
  // order so an equal later score never displaces an earlier index. Lanes past
  // the end of the frame (padding on the last beat) are skipped.
  always_comb begin
    chain_max = max_q;
    chain_sec = sec_q;
    chain_idx = idx_q;
    lane_v    = '0;
    lane_cls  = 0;
    for (int k = 0; k < LANES; k++) begin
      lane_v   = IN_DATA[k*DATA_W +: DATA_W];
      lane_cls = int'(cnt_q) * LANES + k;
      if (lane_cls < N_CLASSES) begin
        if (lane_v > chain_max) begin
          chain_sec = chain_max;
          chain_max = lane_v;
          chain_idx = IDX_W'(lane_cls);
        end else if (lane_v > chain_sec) begin
          chain_sec = lane_v;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    sec_d     = sec_q;
    idx_d     = idx_q;
    largest_d = largest_q;
    second_d  = second_q;
    index_d   = index_q;
    margin_d  = margin_q;
    rvalid_d  = rvalid_q;
    abort_d   = 1'b0;

    // FINAL always completes; a START seen there is dropped.
    open_frame = EN && START && (state_q != S_FINAL);
    // A beat arriving alongside START belongs to the discarded frame.
    beat_fire  = EN && IN_VALID && (state_q == S_ACCUM) && !START;

    if (open_frame) begin
      abort_d = (state_q == S_ACCUM);
      state_d = S_ACCUM;
      cnt_d   = '0;
      max_d   = MOST_NEG;
      sec_d   = MOST_NEG;
      idx_d   = '0;
      if (state_q == S_IDLE) begin
        rvalid_d = 1'b0;
      end
    end else if (beat_fire) begin
      max_d = chain_max;
      sec_d = chain_sec;
      idx_d = chain_idx;
      if (cnt_q == LAST_BEAT) begin
        // Results are captured on the last-beat edge so they are already
        // visible during the FINAL cycle that carries DONE.
        state_d   = S_FINAL;
        cnt_d     = '0;
        largest_d = chain_max;
        second_d  = chain_sec;
        index_d   = chain_idx;
        margin_d  = {chain_max[DATA_W-1], chain_max} - {chain_sec[DATA_W-1], chain_sec};
        rvalid_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == S_FINAL && EN) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLKEXT or posedge RST_ARGMAX) begin
    if (RST_ARGMAX) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      max_q     <= MOST_NEG;
      sec_q     <= MOST_NEG;
      idx_q     <= '0;
      largest_q <= '0;
      second_q  <= '0;
      index_q   <= '0;
      margin_q  <= '0;
      rvalid_q  <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      sec_q     <= sec_d;
      idx_q     <= idx_d;
      largest_q <= largest_d;
      second_q  <= second_d;
      index_q   <= index_d;
      margin_q  <= margin_d;
      rvalid_q  <= rvalid_d;
      abort_q   <= abort_d;
    end
  end

  assign IN_READY     = EN && (state_q == S_ACCUM);
  assign DONE         = EN && (state_q == S_FINAL);
  assign BUSY         = (state_q != S_IDLE);
  assign ABORT        = abort_q;
  assign RESULT_VALID = rvalid_q;
  assign LARGEST      = largest_q;
  assign SECOND       = second_q;
  assign INDEX        = index_q;
  assign MARGIN       = margin_q;

endmodule
